// File: rtl/pcie_dl_pkg.sv
// Data-link layer types shared by the DLLP receive path and its bench.
package pcie_dl_pkg;

  typedef enum logic [1:0] {
    DL_INACTIVE = 2'd0,
    DL_INIT     = 2'd1,
    DL_ACTIVE   = 2'd2
  } pcie_dl_status_e;

endpackage

// File: rtl/pcie_datalink_crc.sv
// 16-bit DLLP CRC (x^16+x^12+x^3+x+1) over one 32-bit word.
// Byte0 [7:0] goes in first, and each byte goes in LSB first.
module pcie_datalink_crc (
  input  logic [15:0] crcIn,
  input  logic [31:0] data,
  output logic [15:0] crcOut
);

  localparam logic [15:0] POLY = 16'h100B;

  always_comb begin
    logic [15:0] crc;
    logic        fb;
    crc = crcIn;
    fb  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      fb  = crc[15] ^ data[i];
      crc = {crc[14:0], 1'b0} ^ ({16{fb}} & POLY);
    end
    crcOut = crc;
  end

endmodule

// File: rtl/dllp_receive.sv
// Receives two-beat DLLPs, checks the CRC and decodes Ack/Nak and flow-control DLLPs.
// Build option: define DLLP_RECEIVE_STATS_EN to include the good/error statistics counters.
module dllp_receive
  import pcie_dl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  pcie_dl_status_e       link_status_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic                  ack_valid_o,
  output logic                  ack_nak_o,
  output logic [11:0]           ack_seq_o,
  output logic [7:0]            ph_limit_o,
  output logic [7:0]            nph_limit_o,
  output logic [7:0]            cplh_limit_o,
  output logic [11:0]           pd_limit_o,
  output logic [11:0]           npd_limit_o,
  output logic [11:0]           cpld_limit_o,
  output logic                  ph_inf_o,
  output logic                  pd_inf_o,
  output logic                  nph_inf_o,
  output logic                  npd_inf_o,
  output logic                  cplh_inf_o,
  output logic                  cpld_inf_o,
  output logic                  fc_init1_o,
  output logic                  fc_init2_o,
  output logic                  crc_err_o,
  output logic [15:0]           good_cnt_o,
  output logic [15:0]           err_cnt_o
);

  typedef enum logic [1:0] {
    ST_BODY = 2'd0,
    ST_CRC  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam logic [KEEP_WIDTH-1:0] KEEP_BODY = KEEP_WIDTH'(4'hF);
  localparam logic [KEEP_WIDTH-1:0] KEEP_CRC  = KEEP_WIDTH'(4'h3);
  localparam logic [1:0]            CLS_INIT1 = 2'b01;

  state_e      state_reg;
  state_e      state_next;
  logic        tready_reg;
  logic [31:0] body_reg;
  logic [15:0] crc_out;
  logic        beat_acc;
  logic        body_ok;
  logic        crc_match;
  logic        body_load;
  logic        dllp_good;
  logic        dllp_bad;
  logic        crc_err_reg;
  logic        ack_valid_reg;
  logic        ack_nak_reg;
  logic [11:0] ack_seq_reg;

  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  assign beat_acc  = s_axis_tvalid & tready_reg;
  assign body_ok   = (s_axis_tkeep == KEEP_BODY) && !s_axis_tlast;
  assign crc_match = (s_axis_tdata[15:0] == ~crc_out);

  pcie_datalink_crc u_crc (
    .crcIn  (16'hFFFF),
    .data   (body_reg),
    .crcOut (crc_out)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= ST_BODY;
      tready_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tready_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (beat_acc) begin
      case (state_reg)
        ST_BODY: if (body_ok) state_next = ST_CRC;
        ST_CRC:  state_next = s_axis_tlast ? ST_BODY : ST_DROP;
        ST_DROP: if (s_axis_tlast) state_next = ST_BODY;
        default: state_next = ST_BODY;
      endcase
    end
  end

  // Beats seen in ST_DROP are silently discarded; the error was already flagged on entry.
  always_comb begin
    body_load = 1'b0;
    dllp_good = 1'b0;
    dllp_bad  = 1'b0;
    if (beat_acc) begin
      case (state_reg)
        ST_BODY: begin
          if (body_ok) body_load = 1'b1;
          else         dllp_bad  = 1'b1;
        end
        ST_CRC: begin
          if (s_axis_tlast && (s_axis_tkeep == KEEP_CRC) && crc_match) dllp_good = 1'b1;
          else                                                         dllp_bad  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      body_reg <= '0;
    end else if (body_load) begin
      body_reg <= s_axis_tdata[31:0];
    end
  end

  // Field decode from the latched body.
  logic [7:0]  byte0;
  logic [1:0]  fc_cls;
  logic [1:0]  fc_sel;
  logic        fc_is_init;
  logic        fc_valid;
  logic        fc_apply;
  logic        link_down;
  logic        is_ack_nak;
  logic [7:0]  hdr_fc;
  logic [11:0] data_fc;

  assign byte0      = body_reg[7:0];
  assign fc_cls     = byte0[7:6];
  assign fc_sel     = byte0[5:4];
  assign fc_is_init = fc_cls[0];
  assign fc_valid   = (byte0[3:0] == 4'h0) && (fc_sel != 2'b11) && (fc_cls != 2'b00);
  assign link_down  = (link_status_i == DL_INACTIVE);
  assign fc_apply   = dllp_good && fc_valid && !link_down;
  assign is_ack_nak = (byte0 == 8'h00) || (byte0 == 8'h10);
  assign hdr_fc     = {body_reg[13:8], body_reg[23:22]};
  assign data_fc    = {body_reg[19:16], body_reg[31:24]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_err_reg   <= 1'b0;
      ack_valid_reg <= 1'b0;
      ack_nak_reg   <= 1'b0;
      ack_seq_reg   <= '0;
    end else begin
      crc_err_reg   <= dllp_bad;
      ack_valid_reg <= dllp_good && is_ack_nak;
      if (dllp_good && is_ack_nak) begin
        ack_nak_reg <= byte0[4];
        ack_seq_reg <= data_fc;
      end
    end
  end

  // Per-type credit state, index 0 = Posted, 1 = Non-Posted, 2 = Completion.
  logic [2:0][7:0]  hdr_lim;
  logic [2:0][11:0] data_lim;
  logic [2:0]       hdr_inf;
  logic [2:0]       data_inf;
  logic [2:0]       init1_seen;
  logic [2:0]       init2_seen;

  for (genvar gi = 0; gi < 3; gi++) begin : g_fc
    logic [7:0]  hdr_lim_reg;
    logic [11:0] data_lim_reg;
    logic        hdr_inf_reg;
    logic        data_inf_reg;
    logic        init1_reg;
    logic        init2_reg;
    logic        hit;

    assign hit = fc_apply && (fc_sel == 2'(gi));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hdr_lim_reg  <= '0;
        data_lim_reg <= '0;
        hdr_inf_reg  <= 1'b0;
        data_inf_reg <= 1'b0;
        init1_reg    <= 1'b0;
        init2_reg    <= 1'b0;
      end else if (link_down) begin
        hdr_lim_reg  <= '0;
        data_lim_reg <= '0;
        hdr_inf_reg  <= 1'b0;
        data_inf_reg <= 1'b0;
        init1_reg    <= 1'b0;
        init2_reg    <= 1'b0;
      end else if (hit) begin
        if (fc_is_init) begin
          hdr_lim_reg  <= hdr_fc;
          data_lim_reg <= data_fc;
          hdr_inf_reg  <= (hdr_fc == 8'd0);
          data_inf_reg <= (data_fc == 12'd0);
          if (fc_cls == CLS_INIT1) init1_reg <= 1'b1;
          else                     init2_reg <= 1'b1;
        end else begin
          // An infinite-credit field never changes on UpdateFC.
          if (!hdr_inf_reg)  hdr_lim_reg  <= hdr_fc;
          if (!data_inf_reg) data_lim_reg <= data_fc;
        end
      end
    end

    assign hdr_lim[gi]    = hdr_lim_reg;
    assign data_lim[gi]   = data_lim_reg;
    assign hdr_inf[gi]    = hdr_inf_reg;
    assign data_inf[gi]   = data_inf_reg;
    assign init1_seen[gi] = init1_reg;
    assign init2_seen[gi] = init2_reg;
  end

`ifdef DLLP_RECEIVE_STATS_EN
  logic [15:0] good_cnt_reg;
  logic [15:0] err_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      good_cnt_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      if (dllp_good && (good_cnt_reg != 16'hFFFF)) good_cnt_reg <= good_cnt_reg + 16'd1;
      if (dllp_bad && (err_cnt_reg != 16'hFFFF))   err_cnt_reg  <= err_cnt_reg + 16'd1;
    end
  end

  assign good_cnt_o = good_cnt_reg;
  assign err_cnt_o  = err_cnt_reg;
`else
  assign good_cnt_o = '0;
  assign err_cnt_o  = '0;
`endif

  assign s_axis_tready = tready_reg;
  assign ack_valid_o   = ack_valid_reg;
  assign ack_nak_o     = ack_nak_reg;
  assign ack_seq_o     = ack_seq_reg;
  assign crc_err_o     = crc_err_reg;
  assign ph_limit_o    = hdr_lim[0];
  assign nph_limit_o   = hdr_lim[1];
  assign cplh_limit_o  = hdr_lim[2];
  assign pd_limit_o    = data_lim[0];
  assign npd_limit_o   = data_lim[1];
  assign cpld_limit_o  = data_lim[2];
  assign ph_inf_o      = hdr_inf[0];
  assign nph_inf_o     = hdr_inf[1];
  assign cplh_inf_o    = hdr_inf[2];
  assign pd_inf_o      = data_inf[0];
  assign npd_inf_o     = data_inf[1];
  assign cpld_inf_o    = data_inf[2];
  assign fc_init1_o    = &init1_seen;
  assign fc_init2_o    = &init2_seen;

endmodule

// File: tb/tb_dllp_receive.sv
// Directed bench for dllp_receive: Ack/Nak, flow control, CRC/framing errors and reset.
module tb_dllp_receive;
  import pcie_dl_pkg::*;

`ifdef DLLP_RECEIVE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  pcie_dl_status_e link_status_i;
  logic [31:0]     s_axis_tdata;
  logic [3:0]      s_axis_tkeep;
  logic            s_axis_tvalid;
  logic            s_axis_tlast;
  logic [2:0]      s_axis_tuser;
  logic            s_axis_tready;
  logic            ack_valid_o, ack_nak_o;
  logic [11:0]     ack_seq_o;
  logic [7:0]      ph_limit_o, nph_limit_o, cplh_limit_o;
  logic [11:0]     pd_limit_o, npd_limit_o, cpld_limit_o;
  logic            ph_inf_o, pd_inf_o, nph_inf_o, npd_inf_o, cplh_inf_o, cpld_inf_o;
  logic            fc_init1_o, fc_init2_o, crc_err_o;
  logic [15:0]     good_cnt_o, err_cnt_o;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int ack_seen = 0;
  int good_exp = 0;

  dllp_receive dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .link_status_i(link_status_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .ack_valid_o(ack_valid_o), .ack_nak_o(ack_nak_o), .ack_seq_o(ack_seq_o),
    .ph_limit_o(ph_limit_o), .nph_limit_o(nph_limit_o), .cplh_limit_o(cplh_limit_o),
    .pd_limit_o(pd_limit_o), .npd_limit_o(npd_limit_o), .cpld_limit_o(cpld_limit_o),
    .ph_inf_o(ph_inf_o), .pd_inf_o(pd_inf_o), .nph_inf_o(nph_inf_o), .npd_inf_o(npd_inf_o),
    .cplh_inf_o(cplh_inf_o), .cpld_inf_o(cpld_inf_o),
    .fc_init1_o(fc_init1_o), .fc_init2_o(fc_init2_o), .crc_err_o(crc_err_o),
    .good_cnt_o(good_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk_i) begin
    if (crc_err_o === 1'b1) err_seen++;
    if (ack_valid_o === 1'b1) ack_seen++;
  end

  // Reference DLLP CRC: poly 0x100B, seed all-ones, byte0 first, LSB first.
  function automatic logic [15:0] ref_crc(input logic [31:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      if (c[15] != d[i]) c = (c << 1) ^ 16'h100B;
      else               c = c << 1;
    end
    return c;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(posedge clk_i);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_dllp(input logic [31:0] body, input logic [15:0] flip);
    beat(body, 4'hF, 1'b0);
    beat({16'h0000, ~ref_crc(body) ^ flip}, 4'h3, 1'b1);
    if (flip == 16'h0000) good_exp++;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle(2);
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready act=%0b exp=0", s_axis_tready); end
    checks++; if (ack_valid_o !== 1'b0 || ack_seq_o !== 12'h000) begin failures++; $display("FAIL reset_ack act=%0b/%h exp=0/000", ack_valid_o, ack_seq_o); end
    checks++; if ({ph_limit_o, pd_limit_o, nph_limit_o, cpld_limit_o} !== 40'h0) begin failures++; $display("FAIL reset_limits act=%h exp=0", {ph_limit_o, pd_limit_o, nph_limit_o, cpld_limit_o}); end
    checks++; if ({crc_err_o, fc_init1_o, fc_init2_o, ph_inf_o, cpld_inf_o} !== 5'b0) begin failures++; $display("FAIL reset_flags act=%b exp=00000", {crc_err_o, fc_init1_o, fc_init2_o, ph_inf_o, cpld_inf_o}); end
    rst_ni = 1'b1;
    idle(2);
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL tready_after_reset act=%0b exp=1", s_axis_tready); end
  endtask

  task automatic test_ack();
    send_dllp(32'h0500_0000, 16'h0000);
    checks++; if (ack_valid_o !== 1'b1) begin failures++; $display("FAIL ack_valid act=%0b exp=1", ack_valid_o); end
    checks++; if (ack_nak_o !== 1'b0) begin failures++; $display("FAIL ack_nak act=%0b exp=0", ack_nak_o); end
    checks++; if (ack_seq_o !== 12'h005) begin failures++; $display("FAIL ack_seq act=%h exp=005", ack_seq_o); end
    idle(1);
    checks++; if (ack_valid_o !== 1'b0) begin failures++; $display("FAIL ack_pulse_width act=%0b exp=0", ack_valid_o); end
  endtask

  task automatic test_nak();
    send_dllp(32'hBC0A_0010, 16'h0000);
    checks++; if (ack_valid_o !== 1'b1 || ack_nak_o !== 1'b1) begin failures++; $display("FAIL nak_event act=%0b/%0b exp=1/1", ack_valid_o, ack_nak_o); end
    checks++; if (ack_seq_o !== 12'hABC) begin failures++; $display("FAIL nak_seq act=%h exp=abc", ack_seq_o); end
    idle(1);
  endtask

  task automatic test_update_fc();
    int e0 = err_seen;
    send_dllp(32'h4000_0480, 16'h0000);
    checks++; if (ph_limit_o !== 8'h10) begin failures++; $display("FAIL upd_ph act=%h exp=10", ph_limit_o); end
    checks++; if (pd_limit_o !== 12'h040) begin failures++; $display("FAIL upd_pd act=%h exp=040", pd_limit_o); end
    checks++; if (crc_err_o !== 1'b0 || ack_valid_o !== 1'b0) begin failures++; $display("FAIL upd_side act=%0b/%0b exp=0/0", crc_err_o, ack_valid_o); end
    idle(2);
    checks++; if (err_seen - e0 != 0) begin failures++; $display("FAIL upd_err_pulses act=%0d exp=0", err_seen - e0); end
  endtask

  task automatic test_init_inf();
    send_dllp(32'h0000_0050, 16'h0000);
    checks++; if (nph_inf_o !== 1'b1 || npd_inf_o !== 1'b1) begin failures++; $display("FAIL init1_np_inf act=%0b/%0b exp=1/1", nph_inf_o, npd_inf_o); end
    checks++; if (fc_init1_o !== 1'b0) begin failures++; $display("FAIL init1_partial act=%0b exp=0", fc_init1_o); end
    send_dllp(32'h0000_0890, 16'h0000);
    checks++; if (nph_limit_o !== 8'h00 || nph_inf_o !== 1'b1 || npd_inf_o !== 1'b1) begin failures++; $display("FAIL upd_np_inf act=%h/%0b/%0b exp=00/1/1", nph_limit_o, nph_inf_o, npd_inf_o); end
    send_dllp(32'h2381_0840, 16'h0000);
    checks++; if (ph_limit_o !== 8'h22 || pd_limit_o !== 12'h123) begin failures++; $display("FAIL init1_p act=%h/%h exp=22/123", ph_limit_o, pd_limit_o); end
    checks++; if (ph_inf_o !== 1'b0 || pd_inf_o !== 1'b0) begin failures++; $display("FAIL init1_p_inf act=%0b/%0b exp=0/0", ph_inf_o, pd_inf_o); end
    send_dllp(32'h0000_0060, 16'h0000);
    checks++; if (fc_init1_o !== 1'b1 || fc_init2_o !== 1'b0) begin failures++; $display("FAIL init1_all act=%0b/%0b exp=1/0", fc_init1_o, fc_init2_o); end
    checks++; if (cplh_inf_o !== 1'b1 || cpld_inf_o !== 1'b1) begin failures++; $display("FAIL init1_cpl_inf act=%0b/%0b exp=1/1", cplh_inf_o, cpld_inf_o); end
  endtask

  task automatic test_partial_inf();
    send_dllp(32'h0040_01C0, 16'h0000);
    checks++; if (ph_limit_o !== 8'h05 || pd_inf_o !== 1'b1 || ph_inf_o !== 1'b0) begin failures++; $display("FAIL init2_p act=%h/%0b/%0b exp=05/1/0", ph_limit_o, pd_inf_o, ph_inf_o); end
    checks++; if (fc_init2_o !== 1'b0 || fc_init1_o !== 1'b1) begin failures++; $display("FAIL init2_sticky act=%0b/%0b exp=0/1", fc_init2_o, fc_init1_o); end
    send_dllp(32'h5505_0C80, 16'h0000);
    checks++; if (ph_limit_o !== 8'h30 || pd_limit_o !== 12'h000) begin failures++; $display("FAIL upd_p_mixed act=%h/%h exp=30/000", ph_limit_o, pd_limit_o); end
  endtask

  task automatic test_vc_ignore();
    int e0 = err_seen;
    send_dllp(32'h0000_0041, 16'h0000);
    idle(1);
    checks++; if (ph_limit_o !== 8'h30 || ph_inf_o !== 1'b0 || pd_limit_o !== 12'h000) begin failures++; $display("FAIL vc1_ignored act=%h/%0b/%h exp=30/0/000", ph_limit_o, ph_inf_o, pd_limit_o); end
    checks++; if (err_seen - e0 != 0) begin failures++; $display("FAIL vc1_err act=%0d exp=0", err_seen - e0); end
  endtask

  task automatic test_bad_crc();
    int e0 = err_seen;
    int a0 = ack_seen;
    send_dllp(32'h0500_0000, 16'h0001);
    idle(3);
    checks++; if (err_seen - e0 != 1) begin failures++; $display("FAIL badcrc_err_pulses act=%0d exp=1", err_seen - e0); end
    checks++; if (ack_seen - a0 != 0) begin failures++; $display("FAIL badcrc_ack_pulses act=%0d exp=0", ack_seen - a0); end
    checks++; if (err_cnt_o !== (STATS ? 16'd1 : 16'd0)) begin failures++; $display("FAIL badcrc_err_cnt act=%0d exp=%0d", err_cnt_o, STATS ? 1 : 0); end
  endtask

  task automatic test_malformed_drop();
    int e0 = err_seen;
    int a0 = ack_seen;
    beat(32'h0500_0000, 4'hF, 1'b0);
    beat({16'h0, ~ref_crc(32'h0500_0000)}, 4'h3, 1'b0);
    beat(32'hDEAD_BEEF, 4'hF, 1'b0);
    beat(32'h1234_5678, 4'hF, 1'b1);
    send_dllp(32'h2301_0000, 16'h0000);
    checks++; if (ack_valid_o !== 1'b1 || ack_seq_o !== 12'h123) begin failures++; $display("FAIL drop_then_ack act=%0b/%h exp=1/123", ack_valid_o, ack_seq_o); end
    idle(2);
    checks++; if (err_seen - e0 != 1 || ack_seen - a0 != 1) begin failures++; $display("FAIL drop_pulses err=%0d ack=%0d exp=1/1", err_seen - e0, ack_seen - a0); end
    e0 = err_seen;
    beat(32'h0000_0000, 4'hF, 1'b1);
    send_dllp(32'h4402_0000, 16'h0000);
    checks++; if (ack_valid_o !== 1'b1 || ack_seq_o !== 12'h244) begin failures++; $display("FAIL short_body_recover act=%0b/%h exp=1/244", ack_valid_o, ack_seq_o); end
    idle(2);
    checks++; if (err_seen - e0 != 1) begin failures++; $display("FAIL short_body_err act=%0d exp=1", err_seen - e0); end
    checks++; if (err_cnt_o !== (STATS ? 16'd3 : 16'd0)) begin failures++; $display("FAIL err_cnt_total act=%0d exp=%0d", err_cnt_o, STATS ? 3 : 0); end
  endtask

  task automatic test_back_to_back();
    int a0 = ack_seen;
    send_dllp(32'h0100_0000, 16'h0000);
    checks++; if (ack_seq_o !== 12'h001) begin failures++; $display("FAIL b2b_seq1 act=%h exp=001", ack_seq_o); end
    send_dllp(32'h020F_0010, 16'h0000);
    checks++; if (ack_seq_o !== 12'hF02 || ack_nak_o !== 1'b1) begin failures++; $display("FAIL b2b_seq2 act=%h/%0b exp=f02/1", ack_seq_o, ack_nak_o); end
    send_dllp(32'h0300_0000, 16'h0000);
    checks++; if (ack_seq_o !== 12'h003 || ack_nak_o !== 1'b0) begin failures++; $display("FAIL b2b_seq3 act=%h/%0b exp=003/0", ack_seq_o, ack_nak_o); end
    idle(2);
    checks++; if (ack_seen - a0 != 3) begin failures++; $display("FAIL b2b_ack_pulses act=%0d exp=3", ack_seen - a0); end
    checks++; if (good_cnt_o !== (STATS ? 16'(good_exp) : 16'd0)) begin failures++; $display("FAIL good_cnt act=%0d exp=%0d", good_cnt_o, STATS ? good_exp : 0); end
  endtask

  task automatic test_inactive();
    link_status_i = DL_INACTIVE;
    idle(1);
    checks++; if (ph_limit_o !== 8'h00 || nph_inf_o !== 1'b0 || fc_init1_o !== 1'b0) begin failures++; $display("FAIL inactive_clear act=%h/%0b/%0b exp=00/0/0", ph_limit_o, nph_inf_o, fc_init1_o); end
    send_dllp(32'h2381_0840, 16'h0000);
    checks++; if (ph_limit_o !== 8'h00 || pd_limit_o !== 12'h000) begin failures++; $display("FAIL inactive_fc_ignored act=%h/%h exp=00/000", ph_limit_o, pd_limit_o); end
    send_dllp(32'hC503_0000, 16'h0000);
    checks++; if (ack_valid_o !== 1'b1 || ack_seq_o !== 12'h3C5) begin failures++; $display("FAIL inactive_ack act=%0b/%h exp=1/3c5", ack_valid_o, ack_seq_o); end
    link_status_i = DL_ACTIVE;
    idle(1);
  endtask

  task automatic test_reset_mid();
    int e0;
    int a0;
    send_dllp(32'h2381_0840, 16'h0000);
    checks++; if (ph_limit_o !== 8'h22) begin failures++; $display("FAIL pre_reset_ph act=%h exp=22", ph_limit_o); end
    e0 = err_seen;
    a0 = ack_seen;
    beat(32'h0500_0000, 4'hF, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (s_axis_tready !== 1'b0 || ph_limit_o !== 8'h00 || pd_limit_o !== 12'h000) begin failures++; $display("FAIL async_reset act=%0b/%h/%h exp=0/00/000", s_axis_tready, ph_limit_o, pd_limit_o); end
    checks++; if (ack_seq_o !== 12'h000 || good_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) begin failures++; $display("FAIL async_reset_regs act=%h/%0d/%0d exp=000/0/0", ack_seq_o, good_cnt_o, err_cnt_o); end
    idle(2);
    #3 rst_ni = 1'b1;
    idle(2);
    good_exp = 0;
    send_dllp(32'hFF07_0000, 16'h0000);
    checks++; if (ack_valid_o !== 1'b1 || ack_seq_o !== 12'h7FF) begin failures++; $display("FAIL post_reset_ack act=%0b/%h exp=1/7ff", ack_valid_o, ack_seq_o); end
    idle(2);
    checks++; if (err_seen - e0 != 0 || ack_seen - a0 != 1) begin failures++; $display("FAIL reset_pulses err=%0d ack=%0d exp=0/1", err_seen - e0, ack_seen - a0); end
    checks++; if (good_cnt_o !== (STATS ? 16'd1 : 16'd0)) begin failures++; $display("FAIL post_reset_good_cnt act=%0d exp=%0d", good_cnt_o, STATS ? 1 : 0); end
  endtask

  initial begin
    rst_ni        = 1'b0;
    link_status_i = DL_ACTIVE;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    test_reset();
    test_ack();
    test_nak();
    test_update_fc();
    test_init_inf();
    test_partial_inf();
    test_vc_ignore();
    test_bad_crc();
    test_malformed_drop();
    test_back_to_back();
    test_inactive();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
